brick_map: RTL and testbench

Owns the playfield brick occupancy map: a 32×30 grid of 16×16-pixel cells, one bit per cell. On the read side it turns the current scan position into the `show_brick` qualifier consumed by the brick sprite renderer. On the write side it accepts cell set/clear, clear-all and level-load requests from game logic (bullet hits, level start) over a valid/ready handshake. It sits between the game-logic/level-ROM side and the VGA sprite pipeline, in the `vga_clk` domain.

---
 rtl/brick_pkg.sv | 30 +++
 rtl/brick_map.sv | 164 ++++++++++++++++
 tb/tb_brick_map.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brick_pkg.sv
// Shared types and constants for the playfield brick occupancy map.
// The map is a 32x30 grid of 16x16-pixel cells inside a 512x480 play area.
package brick_pkg;

   localparam int GRID_COLS = 32;
   localparam int GRID_ROWS = 30;
   localparam int CELL_LOG2 = 4;

   localparam logic [9:0] PLAY_W   = 10'd512;
   localparam logic [9:0] PLAY_H   = 10'd480;
   localparam logic [4:0] ROW_LAST = 5'(GRID_ROWS - 1);

   typedef enum logic [1:0] {
      OP_CLR_CELL = 2'b00,
      OP_SET_CELL = 2'b01,
      OP_CLR_ALL  = 2'b10,
      OP_LOAD     = 2'b11
   } wr_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CLEAR = 2'b01,
      LOAD  = 2'b10
   } map_state_t;

   function automatic logic in_play(input logic [9:0] x, input logic [9:0] y);
      return (x < PLAY_W) && (y < PLAY_H);
   endfunction

endpackage

// File: rtl/brick_map.sv
// Brick occupancy map: registered show_brick lookup for the sprite pipeline,
// plus cell set/clear, clear-all and pipelined level-ROM load on the write side.
module brick_map
   import brick_pkg::*;
(
   input  logic        vga_clk,
   input  logic        reset_n,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic        show_brick,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [1:0]  wr_op,
   input  logic [4:0]  wr_col,
   input  logic [4:0]  wr_row,
   input  logic [1:0]  wr_level,
   output logic [6:0]  lvl_addr,
   input  logic [31:0] lvl_data,
   output logic        busy
);

   map_state_t           state_r, state_nxt_s;
   logic [4:0]           row_cnt_r, row_cnt_nxt_s;
   logic [1:0]           level_r, level_nxt_s;
   logic                 ld_vld_r, ld_vld_nxt_s;
   logic [4:0]           ld_row_r, ld_row_nxt_s;
   logic [6:0]           lvl_addr_r;
   logic                 show_brick_r;
   logic [GRID_COLS-1:0] map_r [GRID_ROWS];

   logic                 wr_en_s;
   logic [4:0]           wr_idx_s;
   logic [GRID_COLS-1:0] wr_word_s;
   logic [GRID_COLS-1:0] cell_word_s;
   logic [4:0]           rd_col_s;
   logic [4:0]           rd_row_s;
   logic                 hit_s;

   assign rd_col_s   = DrawX[CELL_LOG2 +: 5];
   assign rd_row_s   = DrawY[CELL_LOG2 +: 5];
   assign wr_ready   = (state_r == IDLE);
   assign busy       = (state_r != IDLE);
   assign lvl_addr   = lvl_addr_r;
   assign show_brick = show_brick_r;

   // Combinational map lookup; sees the map before any same-cycle write.
   always_comb begin
      if (in_play(DrawX, DrawY)) begin
         hit_s = map_r[rd_row_s][rd_col_s];
      end else begin
         hit_s = 1'b0;
      end
   end

   // Next-state logic and the single row-write port request.
   always_comb begin
      state_nxt_s   = state_r;
      row_cnt_nxt_s = row_cnt_r;
      level_nxt_s   = level_r;
      ld_vld_nxt_s  = 1'b0;
      ld_row_nxt_s  = ld_row_r;
      wr_en_s       = 1'b0;
      wr_idx_s      = 5'd0;
      wr_word_s     = '0;
      cell_word_s   = '0;
      case (state_r)
         IDLE: begin
            if (wr_valid) begin
               case (wr_op_t'(wr_op))
                  OP_CLR_CELL, OP_SET_CELL: begin
                     if (wr_row <= ROW_LAST) begin
                        cell_word_s         = map_r[wr_row];
                        cell_word_s[wr_col] = wr_op[0];
                        wr_en_s             = 1'b1;
                        wr_idx_s            = wr_row;
                        wr_word_s           = cell_word_s;
                     end else begin
                        wr_en_s = 1'b0;
                     end
                  end
                  OP_CLR_ALL: begin
                     state_nxt_s   = CLEAR;
                     row_cnt_nxt_s = 5'd0;
                  end
                  OP_LOAD: begin
                     state_nxt_s   = LOAD;
                     row_cnt_nxt_s = 5'd0;
                     level_nxt_s   = wr_level;
                  end
                  default: state_nxt_s = IDLE;
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CLEAR: begin
            wr_en_s   = 1'b1;
            wr_idx_s  = row_cnt_r;
            wr_word_s = '0;
            if (row_cnt_r == ROW_LAST) begin
               state_nxt_s = IDLE;
            end else begin
               row_cnt_nxt_s = row_cnt_r + 5'd1;
            end
         end
         LOAD: begin
            // ROM data lags the address by a cycle, so ld_row_r trails row_cnt_r.
            wr_en_s   = ld_vld_r;
            wr_idx_s  = ld_row_r;
            wr_word_s = lvl_data;
            if (ld_vld_r && (ld_row_r == ROW_LAST)) begin
               state_nxt_s = IDLE;
            end else begin
               ld_vld_nxt_s = 1'b1;
               ld_row_nxt_s = row_cnt_r;
               if (row_cnt_r != ROW_LAST) begin
                  row_cnt_nxt_s = row_cnt_r + 5'd1;
               end else begin
                  row_cnt_nxt_s = row_cnt_r;
               end
            end
         end
         default: begin
            state_nxt_s   = IDLE;
            row_cnt_nxt_s = 5'd0;
         end
      endcase
   end

   // Control registers, level-ROM address and the show_brick output flop.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         row_cnt_r    <= 5'd0;
         level_r      <= 2'd0;
         ld_vld_r     <= 1'b0;
         ld_row_r     <= 5'd0;
         lvl_addr_r   <= 7'd0;
         show_brick_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         row_cnt_r    <= row_cnt_nxt_s;
         level_r      <= level_nxt_s;
         ld_vld_r     <= ld_vld_nxt_s;
         ld_row_r     <= ld_row_nxt_s;
         show_brick_r <= hit_s;
         if (state_nxt_s == LOAD) begin
            lvl_addr_r <= {level_nxt_s, row_cnt_nxt_s};
         end
      end
   end

   // Map storage: one row write per cycle, zeroed on reset.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < GRID_ROWS; i++) begin
            map_r[i] <= '0;
         end
      end else if (wr_en_s) begin
         map_r[wr_idx_s] <= wr_word_s;
      end
   end

endmodule

// File: tb/tb_brick_map.sv
// Self-checking bench for brick_map: directed table, multi-cycle sequences and
// randomized cell/clear/load traffic against a cell-array reference model.
module tb_brick_map;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic [9:0]  DrawX, DrawY;
   logic        show_brick;
   logic        wr_valid;
   logic        wr_ready;
   logic [1:0]  wr_op;
   logic [4:0]  wr_col, wr_row;
   logic [1:0]  wr_level;
   logic [6:0]  lvl_addr;
   logic [31:0] lvl_data;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;

   logic [31:0] model [30];

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       exp;
   } vec_t;
   vec_t vecs [10];

   always #5 vga_clk = ~vga_clk;

   brick_map dut (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .show_brick (show_brick),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_op      (wr_op),
      .wr_col     (wr_col),
      .wr_row     (wr_row),
      .wr_level   (wr_level),
      .lvl_addr   (lvl_addr),
      .lvl_data   (lvl_data),
      .busy       (busy)
   );

   function automatic logic [31:0] rom_word(input logic [6:0] a);
      logic [31:0] w;
      if (a[6:5] == 2'd2) begin
         w = 32'hA5A5_0000 | {27'd0, a[4:0]};
      end else begin
         w = {a, 25'd0} ^ (32'h9E37_79B9 * ({25'd0, a} + 32'd1));
      end
      return w;
   endfunction

   // Level ROM: synchronous read, data one cycle after the address.
   always @(posedge vga_clk) lvl_data <= rom_word(lvl_addr);

   // Handshake counter.
   always @(posedge vga_clk) if (wr_valid === 1'b1 && wr_ready === 1'b1) hs_cnt <= hs_cnt + 1;

   function automatic logic exp_show(input int x, input int y);
      if (x >= 512 || y >= 480) return 1'b0;
      return model[y / 16][x / 16];
   endfunction

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic v);
      DrawX = x;
      DrawY = y;
      tick();
      v = show_brick;
   endtask

   task automatic model_clear();
      for (int r = 0; r < 30; r++) model[r] = 32'd0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!wr_ready && n < 200) begin
         n++;
         tick();
      end
      chk("wait_ready", {31'd0, wr_ready}, 32'd1);
   endtask

   task automatic cell_op(input logic [1:0] op, input logic [4:0] row, input logic [4:0] col);
      wait_ready();
      wr_op = op; wr_row = row; wr_col = col; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      if (row < 5'd30) model[row][col] = op[0];
   endtask

   task automatic clear_all();
      int n = 0;
      wait_ready();
      wr_op = 2'b10; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
      chk("clear_busy_cycles", n, 32'd30);
      model_clear();
   endtask

   task automatic load_level(input logic [1:0] lv);
      int n = 0;
      wait_ready();
      wr_op = 2'b11; wr_level = lv; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      while (busy && n < 100) begin
         if (n < 30) chk("lvl_addr_step", {25'd0, lvl_addr}, {25'd0, lv, 5'(n)});
         n++;
         tick();
      end
      chk("load_busy_cycles", n, 32'd31);
      for (int r = 0; r < 30; r++) model[r] = rom_word({lv, 5'(r)});
   endtask

   task automatic sweep_map(input string tag);
      logic [9:0] x, y;
      logic v;
      for (int r = 0; r < 30; r++) begin
         for (int c = 0; c < 32; c++) begin
            x = 10'(c * 16 + int'($urandom_range(0, 15)));
            y = 10'(r * 16 + int'($urandom_range(0, 15)));
            probe(x, y, v);
            chk(tag, {31'd0, v}, {31'd0, exp_show(int'(x), int'(y))});
         end
      end
   endtask

   initial begin
      logic v;
      logic [31:0] word;
      logic [9:0] rx, ry;
      int n, hs0, k;

      vecs[0] = '{10'd85,  10'd60,  1'b1};
      vecs[1] = '{10'd96,  10'd60,  1'b0};
      vecs[2] = '{10'd520, 10'd60,  1'b0};
      vecs[3] = '{10'd80,  10'd48,  1'b1};
      vecs[4] = '{10'd95,  10'd63,  1'b1};
      vecs[5] = '{10'd79,  10'd60,  1'b0};
      vecs[6] = '{10'd85,  10'd47,  1'b0};
      vecs[7] = '{10'd85,  10'd480, 1'b0};
      vecs[8] = '{10'd597, 10'd60,  1'b0};
      vecs[9] = '{10'd85,  10'd572, 1'b0};

      reset_n = 1'b0; DrawX = '0; DrawY = '0; wr_valid = 1'b0;
      wr_op = '0; wr_col = '0; wr_row = '0; wr_level = '0;
      model_clear();
      #1;
      chk("rst_show_brick", {31'd0, show_brick}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("rst_lvl_addr", {25'd0, lvl_addr}, 32'd0);
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // Whole-frame sweep on an empty map.
      for (int y = 0; y < 525; y += 5) begin
         for (int x = 0; x < 800; x += 9) begin
            probe(10'(x), 10'(y), v);
            chk("empty_frame", {31'd0, v}, 32'd0);
         end
      end
      chk("idle_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Single set cell and the directed lookup table.
      cell_op(2'b01, 5'd3, 5'd5);
      for (int i = 0; i < 10; i++) begin
         probe(vecs[i].x, vecs[i].y, v);
         chk($sformatf("vec%0d", i), {31'd0, v}, {31'd0, vecs[i].exp});
      end

      // Level 2 load with step-by-step address check.
      load_level(2'd2);
      word = 32'd0;
      for (int c = 0; c < 32; c++) begin
         probe(10'(c * 16 + 3), 10'(7 * 16 + 8), v);
         word[c] = v;
      end
      chk("row7_after_load", word, 32'hA5A5_0007);
      sweep_map("map_after_load");

      // Clear-all with a set-cell queued behind it.
      wait_ready();
      hs0 = hs_cnt;
      wr_op = 2'b10; wr_valid = 1'b1;
      tick();
      wr_op = 2'b01; wr_row = 5'd10; wr_col = 5'd20;
      n = 0;
      while (!wr_ready && n < 100) begin
         n++;
         tick();
      end
      chk("clr_ready_low_cycles", n, 32'd30);
      tick();
      wr_valid = 1'b0;
      model_clear();
      model[10][20] = 1'b1;
      tick();
      chk("queued_accept_once", hs_cnt, hs0 + 2);
      sweep_map("map_after_clear_queued");

      // Cell op aimed at row 31 is accepted in one cycle and does nothing.
      hs0 = hs_cnt;
      wr_op = 2'b01; wr_row = 5'd31; wr_col = 5'd4; wr_valid = 1'b1;
      chk("row31_ready", {31'd0, wr_ready}, 32'd1);
      tick();
      wr_valid = 1'b0;
      chk("row31_accepted", hs_cnt, hs0 + 1);
      chk("row31_busy", {31'd0, busy}, 32'd0);
      sweep_map("map_after_row31");

      // Randomized traffic against the model.
      for (int i = 0; i < 250; i++) begin
         k = int'($urandom_range(0, 99));
         if (k < 45) begin
            cell_op(2'b01, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         end else if (k < 88) begin
            cell_op(2'b00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         end else if (k < 93) begin
            clear_all();
         end else begin
            load_level(2'($urandom_range(0, 3)));
         end
         for (int p = 0; p < 3; p++) begin
            rx = 10'($urandom_range(0, 1023));
            ry = 10'($urandom_range(0, 1023));
            probe(rx, ry, v);
            chk("rand_probe", {31'd0, v}, {31'd0, exp_show(int'(rx), int'(ry))});
         end
      end
      sweep_map("map_after_random");

      // Asynchronous reset in the middle of a load.
      wait_ready();
      wr_op = 2'b11; wr_level = 2'd1; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      repeat (12) tick();
      chk("load_cycle12_addr", {25'd0, lvl_addr}, {25'd0, 2'd1, 5'd12});
      #2 reset_n = 1'b0;
      #1;
      chk("arst_lvl_addr", {25'd0, lvl_addr}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("arst_show_brick", {31'd0, show_brick}, 32'd0);
      tick();
      reset_n = 1'b1;
      model_clear();
      tick();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      sweep_map("map_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
